// File: rtl/issue_scheduler.sv
// issue_scheduler: row-level sequencer for the issue positioner; optional perf counters under ISSUE_SCHED_PERF_EN.
module issue_scheduler #(
  parameter int NUM_ALLOC = 220,
  parameter int ROW_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           image_dim,
  input  logic [1:0]           padding,
  input  logic [2:0]           stride,
  input  logic [ROW_W-1:0]     num_rows,
  input  logic                 row_issued,
  input  logic [NUM_ALLOC-1:0] allocator_select,
  input  logic [NUM_ALLOC-1:0] alloc_done,
  output logic [7:0]           cfg_image_dim,
  output logic [1:0]           cfg_padding,
  output logic [2:0]           cfg_stride,
  output logic                 advance,
  output logic [ROW_W-1:0]     row_idx,
  output logic                 busy,
`ifdef ISSUE_SCHED_PERF_EN
  output logic [15:0]          stall_cycles,
  output logic [23:0]          frame_cycles,
`endif
  output logic                 frame_done,
  output logic                 collision
);
  typedef enum logic [2:0] {IDLE, ADV, ISSUE, DRAIN, FIN} state_t;
  state_t state_q, state_d;
  logic [NUM_ALLOC-1:0] busy_vec_q, busy_vec_d;
  logic [ROW_W-1:0] row_q, row_d, rows_q, rows_d;
  logic [7:0] img_q, img_d;
  logic [1:0] pad_q, pad_d;
  logic [2:0] str_q, str_d;
  logic coll_q, coll_d, adv_q, busy_q, fd_q;
  logic start_acc, accept_sel;
  always_comb begin
    start_acc = (state_q == IDLE) && start;
    accept_sel = (state_q == ADV) || (state_q == ISSUE) || (state_q == DRAIN);
    state_d = state_q;
    row_d = row_q;
    rows_d = start_acc ? num_rows : rows_q;
    img_d = start_acc ? image_dim : img_q;
    pad_d = start_acc ? padding : pad_q;
    str_d = start_acc ? stride : str_q;
    coll_d = start_acc ? 1'b0 : coll_q | ((state_q != IDLE) && |(allocator_select & busy_vec_q));
    // select wins over a same-cycle done on the same bit
    busy_vec_d = (busy_vec_q & ~alloc_done) | (accept_sel ? allocator_select : '0);
    case (state_q)
      IDLE: if (start) begin
        row_d = '0;
        state_d = (num_rows == '0) ? FIN : ADV;
      end
      ADV: state_d = ISSUE;
      ISSUE: state_d = row_issued ? DRAIN : ISSUE;
      DRAIN: if (busy_vec_q == '0) begin
        state_d = (row_q == rows_q - ROW_W'(1)) ? FIN : ADV;
        row_d = (row_q == rows_q - ROW_W'(1)) ? row_q : row_q + ROW_W'(1);
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      busy_vec_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_vec_q <= '0;
      row_q <= '0;
      rows_q <= '0;
      img_q <= '0;
      pad_q <= '0;
      str_q <= '0;
      coll_q <= 1'b0;
      adv_q <= 1'b0;
      busy_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_vec_q <= busy_vec_d;
      row_q <= row_d;
      rows_q <= rows_d;
      img_q <= img_d;
      pad_q <= pad_d;
      str_q <= str_d;
      coll_q <= coll_d;
      adv_q <= state_d == ADV;
      busy_q <= state_d != IDLE;
      fd_q <= state_d == FIN;
    end
  end
  assign cfg_image_dim = img_q;
  assign cfg_padding = pad_q;
  assign cfg_stride = str_q;
  assign advance = adv_q;
  assign row_idx = row_q;
  assign busy = busy_q;
  assign frame_done = fd_q;
  assign collision = coll_q;
`ifdef ISSUE_SCHED_PERF_EN
  logic [15:0] stall_q, stall_d;
  logic [23:0] fcyc_q, fcyc_d;
  always_comb begin
    stall_d = start_acc ? '0 : (state_q == DRAIN && |busy_vec_q && !(&stall_q)) ? stall_q + 16'd1 : stall_q;
    fcyc_d = start_acc ? '0 : (state_q != IDLE && !(&fcyc_q)) ? fcyc_q + 24'd1 : fcyc_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      fcyc_q <= '0;
    end else begin
      stall_q <= stall_d;
      fcyc_q <= fcyc_d;
    end
  end
  assign stall_cycles = stall_q;
  assign frame_cycles = fcyc_q;
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed checks of issue_scheduler with NUM_ALLOC=8, ROW_W=8.
module tb_issue_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, row_issued = 1'b0;
  logic [7:0] image_dim = '0, num_rows = '0, allocator_select = '0, alloc_done = '0;
  logic [1:0] padding = '0;
  logic [2:0] stride = '0;
  logic [7:0] cfg_image_dim, row_idx;
  logic [1:0] cfg_padding;
  logic [2:0] cfg_stride;
  logic advance, busy, frame_done, collision;
`ifdef ISSUE_SCHED_PERF_EN
  logic [15:0] stall_cycles;
  logic [23:0] frame_cycles;
`endif
  int n_chk = 0, n_fail = 0;

  issue_scheduler #(.NUM_ALLOC(8), .ROW_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .image_dim(image_dim),
    .padding(padding), .stride(stride), .num_rows(num_rows), .row_issued(row_issued),
    .allocator_select(allocator_select), .alloc_done(alloc_done),
    .cfg_image_dim(cfg_image_dim), .cfg_padding(cfg_padding), .cfg_stride(cfg_stride),
    .advance(advance), .row_idx(row_idx), .busy(busy),
`ifdef ISSUE_SCHED_PERF_EN
    .stall_cycles(stall_cycles), .frame_cycles(frame_cycles),
`endif
    .frame_done(frame_done), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [7:0] nr);
    start = 1'b1; num_rows = nr;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_advance", {31'd0, advance}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_cfg", {19'd0, cfg_image_dim, cfg_padding, cfg_stride}, 0);
    rst = 1'b1;
    tick();
    image_dim = 8'd230; padding = 2'd1; stride = 3'd1;
    go(8'd2);
    chk("cfg_img", {24'd0, cfg_image_dim}, 230);
    chk("cfg_pad", {30'd0, cfg_padding}, 1);
    chk("cfg_str", {29'd0, cfg_stride}, 1);
    chk("adv_c1", {31'd0, advance}, 1);
    chk("busy_c1", {31'd0, busy}, 1);
    chk("row0", {24'd0, row_idx}, 0);
    tick();
    chk("adv_c2", {31'd0, advance}, 0);
    allocator_select = 8'h0F;
    tick();
    allocator_select = 8'h00; row_issued = 1'b1;
    tick();
    row_issued = 1'b0;
    tick();
    chk("drain_wait_adv", {31'd0, advance}, 0);
    alloc_done = 8'h0F;
    tick();
    chk("drain_done_adv", {31'd0, advance}, 0);
    alloc_done = 8'h00;
    tick();
    chk("adv_row1", {31'd0, advance}, 1);
    chk("row1", {24'd0, row_idx}, 1);
    tick();
    allocator_select = 8'hF0; row_issued = 1'b1;
    tick();
    allocator_select = 8'h00; row_issued = 1'b0;
    tick();
    chk("row1_hold_fd", {31'd0, frame_done}, 0);
    alloc_done = 8'hF0;
    tick();
    alloc_done = 8'h00;
    tick();
    chk("fd_pulse", {31'd0, frame_done}, 1);
    chk("fd_busy", {31'd0, busy}, 1);
    chk("fd_adv", {31'd0, advance}, 0);
    tick();
    chk("fd_end", {31'd0, frame_done}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("coll_clean", {31'd0, collision}, 0);

    go(8'd1);
    tick();
    allocator_select = 8'h01;
    tick();
    allocator_select = 8'h01; row_issued = 1'b1;
    tick();
    row_issued = 1'b0;
    chk("coll_set", {31'd0, collision}, 1);
    allocator_select = 8'h01; alloc_done = 8'h01;
    tick();
    allocator_select = 8'h00; alloc_done = 8'h80;
    tick();
    alloc_done = 8'h00;
    tick();
    chk("sel_wins_fd", {31'd0, frame_done}, 0);
    chk("sel_wins_busy", {31'd0, busy}, 1);
    alloc_done = 8'h01;
    tick();
    alloc_done = 8'h00;
    tick();
    chk("coll_fd", {31'd0, frame_done}, 1);
    chk("coll_sticky", {31'd0, collision}, 1);
    tick();
    go(8'd0);
    chk("zero_fd", {31'd0, frame_done}, 1);
    chk("zero_adv", {31'd0, advance}, 0);
    chk("coll_clear", {31'd0, collision}, 0);
    tick();
    chk("zero_idle", {30'd0, busy, frame_done}, 0);

    image_dim = 8'd17;
    go(8'd3);
    image_dim = 8'd99;
    tick();
    start = 1'b1; num_rows = 8'd5; allocator_select = 8'h02; row_issued = 1'b1;
    tick();
    start = 1'b0; allocator_select = 8'h00; row_issued = 1'b0;
    chk("start_ign_adv", {31'd0, advance}, 0);
    chk("start_ign_cfg", {24'd0, cfg_image_dim}, 17);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_fd", {31'd0, frame_done}, 0);
    chk("abort_cfg", {24'd0, cfg_image_dim}, 17);
    tick();
    chk("abort_fd2", {31'd0, frame_done}, 0);
    go(8'd1);
    tick();
    row_issued = 1'b1;
    tick();
    row_issued = 1'b0;
    tick();
    chk("abort_cleared_vec", {31'd0, frame_done}, 1);
    tick();

`ifdef ISSUE_SCHED_PERF_EN
    go(8'd1);
    chk("perf_clear", {8'd0, frame_cycles}, 0);
    tick();
    allocator_select = 8'h01; row_issued = 1'b1;
    tick();
    allocator_select = 8'h00; row_issued = 1'b0;
    tick(); tick();
    alloc_done = 8'h01;
    tick();
    alloc_done = 8'h00;
    tick(); tick();
    chk("perf_stall", {16'd0, stall_cycles}, 3);
    chk("perf_frame", {8'd0, frame_cycles}, 7);
    tick();
    chk("perf_hold", {8'd0, frame_cycles}, 7);
`endif

    go(8'd2);
    rst = 1'b0;
    #1;
    chk("midrst_adv", {31'd0, advance}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_cfg", {24'd0, cfg_image_dim}, 0);
    tick();
    chk("midrst_fd", {31'd0, frame_done}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
